dense_layer_seq: RTL

//  Sequencer for the final fully-connected layer (10 classes) of the fixed-point CIFAR-10 inference chain.

---
 rtl/dense_layer_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dense_layer_seq.sv
// Sequencer for the final fully-connected layer of the CIFAR-10 chain.
// For each output neuron it loads the bias, accumulates NUM_IN weight*feature
// products, streams the saturated Q1.7 logit out, and tracks the argmax class.
module dense_layer_seq #(
    parameter int NUM_IN  = 64,
    parameter int NUM_OUT = 10,
    parameter int ACC_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  class_idx,
    output logic [15:0] w_row,
    output logic [15:0] w_col,
    input  logic [7:0]  w_data,
    output logic [15:0] b_row,
    output logic [15:0] b_col,
    input  logic [7:0]  b_data,
    output logic [15:0] in_addr,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [3:0]  out_idx
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIAS = 3'd1,
        MAC  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [15:0] LAST_I = 16'(NUM_IN - 1);
    localparam logic [3:0]  LAST_N = 4'(NUM_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    state_t state_reg, state_next;

    logic [3:0]              n_reg;
    logic [15:0]             i_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [7:0]       out_data_reg;
    logic [3:0]              out_idx_reg;
    logic signed [7:0]       best_reg;
    logic [3:0]              best_idx_reg;
    logic [3:0]              class_idx_reg;

    // Datapath helpers: 8x8 signed product fits exactly in 16 bits.
    logic signed [15:0]      w_ext;
    logic signed [15:0]      x_ext;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shift;
    logic signed [7:0]       sat_val;
    logic                    last_i;
    logic                    last_n;
    logic                    take_new;

    assign w_ext     = {{8{w_data[7]}}, w_data};
    assign x_ext     = {{8{in_data[7]}}, in_data};
    assign prod      = w_ext * x_ext;
    assign prod_ext  = {{(ACC_W-16){prod[15]}}, prod};
    // Q1.7 bias moved up to the Q2.14 product scale.
    assign bias_ext  = {{(ACC_W-15){b_data[7]}}, b_data, 7'b0};
    assign acc_sum   = acc_reg + prod_ext;
    assign acc_shift = acc_sum >>> 7;
    assign last_i    = (i_reg == LAST_I);
    assign last_n    = (n_reg == LAST_N);
    // Strictly greater keeps the lower index on ties.
    assign take_new  = (n_reg == 4'd0) || (out_data_reg > best_reg);

    // Clamp the rescaled accumulator into the 8-bit Q1.7 range.
    always_comb begin
        sat_val = acc_shift[7:0];
        if (acc_shift > SAT_HI) begin
            sat_val = 8'sh7f;
        end else if (acc_shift < SAT_LO) begin
            sat_val = 8'sh80;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = BIAS;
            BIAS: state_next = MAC;
            MAC:  if (last_i) state_next = EMIT;
            EMIT: if (out_ready) state_next = last_n ? DONE : BIAS;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters, accumulator, output holding registers and argmax tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg         <= '0;
            i_reg         <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            best_reg      <= '0;
            best_idx_reg  <= '0;
            class_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_reg <= '0;
                        i_reg <= '0;
                    end
                end
                BIAS: begin
                    acc_reg <= bias_ext;
                    i_reg   <= '0;
                end
                MAC: begin
                    acc_reg <= acc_sum;
                    if (last_i) begin
                        // Logit is captured here so it stays frozen through EMIT back-pressure.
                        i_reg        <= '0;
                        out_data_reg <= sat_val;
                        out_idx_reg  <= n_reg;
                    end else begin
                        i_reg <= i_reg + 16'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (take_new) begin
                            best_reg     <= out_data_reg;
                            best_idx_reg <= n_reg;
                        end
                        if (last_n) begin
                            class_idx_reg <= take_new ? n_reg : best_idx_reg;
                        end else begin
                            n_reg <= n_reg + 4'd1;
                        end
                    end
                end
                DONE: begin
                    n_reg <= '0;
                end
                default: begin
                    n_reg <= '0;
                end
            endcase
        end
    end

    assign busy      = (state_reg == BIAS) || (state_reg == MAC) || (state_reg == EMIT);
    assign done      = (state_reg == DONE);
    assign out_valid = (state_reg == EMIT);
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign class_idx = class_idx_reg;
    assign w_row     = {12'd0, n_reg};
    assign b_row     = {12'd0, n_reg};
    assign w_col     = i_reg;
    assign in_addr   = i_reg;
    assign b_col     = 16'd0;

endmodule
